alu_control_sequencer: RTL and testbench

Hardwired control unit that drives the datapath's control inputs for instruction fetch and register-to-register ALU instructions.
- Sits directly upstream of the datapath and replaces the hand-written T0–T5 stimulus.
- Reads the instruction register (IR) back from the datapath.
- Produces one-hot register enables, bus-drive selects, ALU opcode and memory read strobe per T-state.
- Stalls the fetch on a memory-ready handshake.

---
 rtl/alu_control_sequencer_if.sv | 36 +++
 rtl/alu_control_sequencer.sv | 166 ++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_control_sequencer_if.sv
// Control bundle between the hardwired sequencer (master) and the datapath (slave):
// IR readback and memory handshake in, register enables, bus strobes and ALU opcode out.
interface alu_control_sequencer_if #(
    parameter int NREGS = 16
);
    logic [31:0]      IR;
    logic             MemReady;
    logic [NREGS-1:0] Rin;
    logic [NREGS-1:0] Rout;
    logic             PCin;
    logic             PCout;
    logic             MARin;
    logic             MDRin;
    logic             MDRout;
    logic             IRin;
    logic             Yin;
    logic             Zlowin;
    logic             Zlowout;
    logic             IncPC;
    logic             Read;
    logic [3:0]       ALUop;
    logic             Run;
    logic             Illegal;

    modport master (
        input  IR, MemReady,
        output Rin, Rout, PCin, PCout, MARin, MDRin, MDRout, IRin,
               Yin, Zlowin, Zlowout, IncPC, Read, ALUop, Run, Illegal
    );

    modport slave (
        output IR, MemReady,
        input  Rin, Rout, PCin, PCout, MARin, MDRin, MDRout, IRin,
               Yin, Zlowin, Zlowout, IncPC, Read, ALUop, Run, Illegal
    );
endinterface

// File: rtl/alu_control_sequencer.sv
// Hardwired T-state control unit for fetch plus register-to-register ALU instructions.
// Optional build macro CTRL_ILLEGAL_TRAP_EN: an illegal opcode halts instead of acting as a nop.
module alu_control_sequencer #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic                     clock,
    input  logic                     clear,
    alu_control_sequencer_if.master  bus
);
    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T1W  = 4'd3,
        ST_T2   = 4'd4,
        ST_T3   = 4'd5,
        ST_T4   = 4'd6,
        ST_T5   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00001;
    localparam logic [OPW-1:0] OP_AND  = 5'b00010;
    localparam logic [OPW-1:0] OP_OR   = 5'b00011;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    state_t         state_r;
    logic [OPW-1:0] opcode_s;
    logic [3:0]     ra_s;
    logic [3:0]     rb_s;
    logic [3:0]     rc_s;
    logic           is_alu_s;
    logic           is_nop_s;
    logic           is_halt_s;
    logic           unused_ir_s;

    assign opcode_s    = bus.IR[31:32-OPW];
    assign ra_s        = bus.IR[26:23];
    assign rb_s        = bus.IR[22:19];
    assign rc_s        = bus.IR[18:15];
    assign unused_ir_s = ^bus.IR[14:0];

    function automatic logic [NREGS-1:0] reg_select(input logic [3:0] idx);
        return {{(NREGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [3:0] alu_code(input logic [OPW-1:0] op);
        case (op)
            OP_ADD:  return 4'd0;
            OP_SUB:  return 4'd3;
            OP_AND:  return 4'd1;
            OP_OR:   return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    // Opcode classification; anything not recognised is illegal
    always_comb begin
        is_alu_s  = 1'b0;
        is_nop_s  = 1'b0;
        is_halt_s = 1'b0;
        case (opcode_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR: is_alu_s  = 1'b1;
            OP_NOP:                        is_nop_s  = 1'b1;
            OP_HALT:                       is_halt_s = 1'b1;
            default:                       is_alu_s  = 1'b0;
        endcase
    end

    // State register with synchronous clear; MemReady only matters in T1/T1W
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r <= ST_RST;
        end else begin
            case (state_r)
                ST_RST:  state_r <= ST_T0;
                ST_T0:   state_r <= ST_T1;
                ST_T1:   state_r <= bus.MemReady ? ST_T2 : ST_T1W;
                ST_T1W:  state_r <= bus.MemReady ? ST_T2 : ST_T1W;
                ST_T2:   state_r <= ST_T3;
                ST_T3: begin
                    if (is_alu_s) begin
                        state_r <= ST_T4;
                    end else if (is_halt_s) begin
                        state_r <= ST_HALT;
                    end else if (is_nop_s) begin
                        state_r <= ST_T0;
                    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_r <= ST_HALT;
`else
                        state_r <= ST_T0;
`endif
                    end
                end
                ST_T4:   state_r <= ST_T5;
                ST_T5:   state_r <= ST_T0;
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_RST;
            endcase
        end
    end

    // Moore strobes decoded from the state; IR is already loaded when T3 is reached
    always_comb begin
        bus.Rin     = '0;
        bus.Rout    = '0;
        bus.PCin    = 1'b0;
        bus.PCout   = 1'b0;
        bus.MARin   = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.Zlowin  = 1'b0;
        bus.Zlowout = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.ALUop   = 4'd0;
        bus.Run     = (state_r != ST_RST) && (state_r != ST_HALT);
        bus.Illegal = 1'b0;
        case (state_r)
            ST_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
            end
            ST_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            ST_T1W: begin
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
            end
            ST_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            ST_T3: begin
                if (is_alu_s) begin
                    bus.Rout = reg_select(rb_s);
                    bus.Yin  = 1'b1;
                end else begin
                    bus.Illegal = !is_nop_s && !is_halt_s;
                end
            end
            ST_T4: begin
                bus.Rout   = reg_select(rc_s);
                bus.ALUop  = alu_code(opcode_s);
                bus.Zlowin = 1'b1;
            end
            ST_T5: begin
                bus.Zlowout = 1'b1;
                bus.Rin     = reg_select(ra_s);
            end
            default: bus.Run = bus.Run;
        endcase
    end
endmodule

// File: tb/tb_alu_control_sequencer.sv
// Self-checking bench for alu_control_sequencer: instruction table expanded into a per-cycle
// queue of expected output words, each popped and compared while the DUT runs.
module tb_alu_control_sequencer;
    localparam int K_ALU = 0, K_NOP = 1, K_ILL = 2, K_HALT = 3;

    // strobe order: PCin PCout MARin MDRin MDRout IRin Yin Zlowin Zlowout IncPC Read
    localparam logic [10:0] S_T0   = 11'b011_0000_1010;
    localparam logic [10:0] S_T1   = 11'b100_1000_0101;
    localparam logic [10:0] S_T1W  = 11'b000_1000_0001;
    localparam logic [10:0] S_T2   = 11'b000_0110_0000;
    localparam logic [10:0] S_YIN  = 11'b000_0001_0000;
    localparam logic [10:0] S_ZIN  = 11'b000_0000_1000;
    localparam logic [10:0] S_ZOUT = 11'b000_0000_0100;
    localparam logic [10:0] S_NONE = 11'b000_0000_0000;

    typedef struct {
        string       name;
        logic [31:0] ir;
        int          stalls;
        int          kind;
        logic [15:0] rout_b;
        logic [15:0] rout_c;
        logic [15:0] rin;
        logic [3:0]  aluop;
    } vec_t;

    typedef struct {
        logic        clr;
        logic [31:0] ir;
        logic        mr;
        logic        mr_rand;
        logic [48:0] exp;
        string       tag;
    } cyc_t;

    logic  clock;
    logic  clear;
    int    total;
    int    bad;
    vec_t  vecs[9];
    cyc_t  q[$];

    alu_control_sequencer_if #(.NREGS(16)) bus();

    alu_control_sequencer #(.NREGS(16), .OPW(5)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [48:0] mk(input logic [15:0] rin, input logic [15:0] rout,
                                       input logic [10:0] st, input logic [3:0] op,
                                       input logic run, input logic ill);
        return {rin, rout, st, op, run, ill};
    endfunction

    function automatic logic [48:0] actual();
        return {bus.Rin, bus.Rout, bus.PCin, bus.PCout, bus.MARin, bus.MDRin, bus.MDRout,
                bus.IRin, bus.Yin, bus.Zlowin, bus.Zlowout, bus.IncPC, bus.Read,
                bus.ALUop, bus.Run, bus.Illegal};
    endfunction

    task automatic check(input string tag, input logic [48:0] exp);
        logic [48:0] act;
        act = actual();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic push(input logic clr, input logic [31:0] ir, input logic mr,
                        input logic rnd, input logic [48:0] exp, input string tag);
        cyc_t c;
        c.clr = clr; c.ir = ir; c.mr = mr; c.mr_rand = rnd; c.exp = exp; c.tag = tag;
        q.push_back(c);
    endtask

    // HALT cycle with clear raised, then the RST cycle
    task automatic push_restart(input string name);
        push(1'b1, 32'h0, 1'b0, 1'b1, 49'd0, {name, "/clr"});
        push(1'b0, 32'h0, 1'b0, 1'b1, 49'd0, {name, "/RST"});
    endtask

    task automatic push_instr(input vec_t v);
        push(1'b0, v.ir, 1'b0, 1'b1, mk(16'h0, 16'h0, S_T0, 4'd0, 1'b1, 1'b0), {v.name, "/T0"});
        push(1'b0, v.ir, (v.stalls == 0), 1'b0, mk(16'h0, 16'h0, S_T1, 4'd0, 1'b1, 1'b0), {v.name, "/T1"});
        for (int i = 0; i < v.stalls; i++)
            push(1'b0, v.ir, (i == v.stalls - 1), 1'b0, mk(16'h0, 16'h0, S_T1W, 4'd0, 1'b1, 1'b0),
                 {v.name, "/T1W"});
        push(1'b0, v.ir, 1'b0, 1'b1, mk(16'h0, 16'h0, S_T2, 4'd0, 1'b1, 1'b0), {v.name, "/T2"});
        case (v.kind)
            K_ALU: begin
                push(1'b0, v.ir, 1'b0, 1'b1, mk(16'h0, v.rout_b, S_YIN, 4'd0, 1'b1, 1'b0), {v.name, "/T3"});
                push(1'b0, v.ir, 1'b0, 1'b1, mk(16'h0, v.rout_c, S_ZIN, v.aluop, 1'b1, 1'b0), {v.name, "/T4"});
                push(1'b0, v.ir, 1'b0, 1'b1, mk(v.rin, 16'h0, S_ZOUT, 4'd0, 1'b1, 1'b0), {v.name, "/T5"});
            end
            K_NOP: push(1'b0, v.ir, 1'b0, 1'b1, mk(16'h0, 16'h0, S_NONE, 4'd0, 1'b1, 1'b0), {v.name, "/T3"});
            K_ILL: begin
                push(1'b0, v.ir, 1'b0, 1'b1, mk(16'h0, 16'h0, S_NONE, 4'd0, 1'b1, 1'b1), {v.name, "/T3"});
`ifdef CTRL_ILLEGAL_TRAP_EN
                push(1'b0, v.ir, 1'b0, 1'b1, 49'd0, {v.name, "/HALT"});
                push_restart(v.name);
`endif
            end
            K_HALT: begin
                push(1'b0, v.ir, 1'b0, 1'b1, mk(16'h0, 16'h0, S_NONE, 4'd0, 1'b1, 1'b0), {v.name, "/T3"});
                for (int i = 0; i < 10; i++)
                    push(1'b0, v.ir, 1'b0, 1'b1, 49'd0, {v.name, "/HALT"});
                push_restart(v.name);
            end
            default: push(1'b0, v.ir, 1'b0, 1'b1, 49'd0, {v.name, "/bad_kind"});
        endcase
    endtask

    initial begin
        cyc_t c;
        total = 0;
        bad   = 0;
        //          name     ir            stalls kind    rout_b    rout_c    rin       aluop
        vecs[0] = '{"and",   32'h112B0000, 0, K_ALU,  16'h0020, 16'h0040, 16'h0004, 4'd1};
        vecs[1] = '{"sub",   32'h089A0000, 0, K_ALU,  16'h0008, 16'h0010, 16'h0002, 4'd3};
        vecs[2] = '{"or_st", 32'h18780000, 3, K_ALU,  16'h8000, 16'h0001, 16'h0001, 4'd2};
        vecs[3] = '{"add",   32'h07838000, 1, K_ALU,  16'h0001, 16'h0080, 16'h8000, 4'd0};
        vecs[4] = '{"nop",   32'hD0000000, 2, K_NOP,  16'h0,    16'h0,    16'h0,    4'd0};
        vecs[5] = '{"ill",   32'h78000000, 0, K_ILL,  16'h0,    16'h0,    16'h0,    4'd0};
        vecs[6] = '{"and2",  32'h112B0000, 0, K_ALU,  16'h0020, 16'h0040, 16'h0004, 4'd1};
        vecs[7] = '{"halt",  32'hD8000000, 0, K_HALT, 16'h0,    16'h0,    16'h0,    4'd0};
        vecs[8] = '{"sub2",  32'h089A0000, 0, K_ALU,  16'h0008, 16'h0010, 16'h0002, 4'd3};

        for (int i = 0; i < 7; i++) push_instr(vecs[i]);
        // clear in the middle of a stalled fetch
        push(1'b0, 32'h0, 1'b0, 1'b1, mk(16'h0, 16'h0, S_T0, 4'd0, 1'b1, 1'b0), "abort/T0");
        push(1'b0, 32'h0, 1'b0, 1'b0, mk(16'h0, 16'h0, S_T1, 4'd0, 1'b1, 1'b0), "abort/T1");
        push(1'b1, 32'h0, 1'b0, 1'b0, mk(16'h0, 16'h0, S_T1W, 4'd0, 1'b1, 1'b0), "abort/T1W");
        push(1'b0, 32'h0, 1'b0, 1'b1, 49'd0, "abort/RST");
        push_instr(vecs[7]);
        push_instr(vecs[8]);

        clear        = 1'b1;
        bus.IR       = 32'h0;
        bus.MemReady = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("reset1", 49'd0);
        @(posedge clock);
        @(negedge clock);
        check("reset2", 49'd0);
        clear = 1'b0;
        @(negedge clock);

        while (q.size() > 0) begin
            c = q.pop_front();
            clear        = c.clr;
            bus.IR       = c.ir;
            bus.MemReady = c.mr_rand ? 1'($urandom_range(1, 0)) : c.mr;
            #1;
            check(c.tag, c.exp);
            @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
